core_bus_arbiter: RTL



---
 rtl/core_bus_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
// Arbitrates the core's instruction bus (ibus) and data bus (dbus) onto one
// memory request channel. One transaction is outstanding at a time; the
// winning request is latched so the memory side sees stable fields until it
// signals completion.
//
// Ports:
//   clk, reset            core clock, asynchronous active-low reset
//   ireq_*                instruction fetch request (valid, 64-bit address)
//   iresp_*               fetch accept/data pulses, 32-bit instruction word
//   dreq_*                data request (valid, address, size, strobe, data)
//   dresp_*               data accept/done pulses, 64-bit load data
//   mreq_*                latched memory request (valid, write, addr, size,
//                         strobe, data)
//   mresp_valid/data      memory completion pulse and read data
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined -> fixed priority, dbus wins simultaneous requests
//   defined   -> 1-bit last-grant register; the bus not granted last wins
module core_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic        mreq_write,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mresp_valid,
  input  logic [63:0] mresp_data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        mreq_valid_q, mreq_valid_d;
  logic        mreq_write_q, mreq_write_d;
  logic [63:0] mreq_addr_q, mreq_addr_d;
  logic [2:0]  mreq_size_q, mreq_size_d;
  logic [7:0]  mreq_strobe_q, mreq_strobe_d;
  logic [63:0] mreq_data_q, mreq_data_d;
  // addr_ok and data_ok always pulse together, so one flop drives both.
  logic        iresp_ok_q, iresp_ok_d;
  logic [31:0] iresp_data_q, iresp_data_d;
  logic        dresp_ok_q, dresp_ok_d;
  logic [63:0] dresp_data_q, dresp_data_d;
  logic        pick_dbus;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = dbus was granted last, 0 = ibus was granted last.
  logic        last_grant_q, last_grant_d;

  // Round robin: dbus wins unless ibus also requests and dbus won last time.
  assign pick_dbus = dreq_valid & (~ireq_valid | ~last_grant_q);
`else
  // Fixed priority: dbus wins whenever it requests.
  assign pick_dbus = dreq_valid;
`endif

  // Next-state, latched request fields and next registered outputs.
  always_comb begin
    state_d       = state_q;
    mreq_valid_d  = mreq_valid_q;
    mreq_write_d  = mreq_write_q;
    mreq_addr_d   = mreq_addr_q;
    mreq_size_d   = mreq_size_q;
    mreq_strobe_d = mreq_strobe_q;
    mreq_data_d   = mreq_data_q;
    iresp_ok_d    = 1'b0;
    iresp_data_d  = iresp_data_q;
    dresp_ok_d    = 1'b0;
    dresp_data_d  = dresp_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d  = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_dbus) begin
          state_d       = ST_BUSY_D;
          mreq_valid_d  = 1'b1;
          mreq_write_d  = |dreq_strobe;
          mreq_addr_d   = dreq_addr;
          mreq_size_d   = dreq_size;
          mreq_strobe_d = dreq_strobe;
          mreq_data_d   = dreq_data;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d  = 1'b1;
`endif
        end else if (ireq_valid) begin
          state_d       = ST_BUSY_I;
          mreq_valid_d  = 1'b1;
          mreq_write_d  = 1'b0;
          mreq_addr_d   = ireq_addr;
          mreq_size_d   = 3'd2;
          mreq_strobe_d = 8'h00;
          mreq_data_d   = 64'h0;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d  = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_I: begin
        if (mresp_valid) begin
          state_d      = ST_RESP_I;
          mreq_valid_d = 1'b0;
          iresp_ok_d   = 1'b1;
          // Latched addr[2] picks the 32-bit half holding the instruction.
          iresp_data_d = mreq_addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
        end else begin
          state_d = ST_BUSY_I;
        end
      end
      ST_BUSY_D: begin
        if (mresp_valid) begin
          state_d      = ST_RESP_D;
          mreq_valid_d = 1'b0;
          dresp_ok_d   = 1'b1;
          dresp_data_d = mresp_data;
        end else begin
          state_d = ST_BUSY_D;
        end
      end
      // RESP is the dead cycle: a still-held request is not resampled here.
      ST_RESP_I: state_d = ST_IDLE;
      ST_RESP_D: state_d = ST_IDLE;
      default: begin
        state_d      = ST_IDLE;
        mreq_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset clears any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mreq_valid_q  <= 1'b0;
      mreq_write_q  <= 1'b0;
      mreq_addr_q   <= 64'h0;
      mreq_size_q   <= 3'd0;
      mreq_strobe_q <= 8'h00;
      mreq_data_q   <= 64'h0;
      iresp_ok_q    <= 1'b0;
      iresp_data_q  <= 32'h0;
      dresp_ok_q    <= 1'b0;
      dresp_data_q  <= 64'h0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mreq_valid_q  <= mreq_valid_d;
      mreq_write_q  <= mreq_write_d;
      mreq_addr_q   <= mreq_addr_d;
      mreq_size_q   <= mreq_size_d;
      mreq_strobe_q <= mreq_strobe_d;
      mreq_data_q   <= mreq_data_d;
      iresp_ok_q    <= iresp_ok_d;
      iresp_data_q  <= iresp_data_d;
      dresp_ok_q    <= dresp_ok_d;
      dresp_data_q  <= dresp_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q  <= last_grant_d;
`endif
    end
  end

  assign mreq_valid    = mreq_valid_q;
  assign mreq_write    = mreq_write_q;
  assign mreq_addr     = mreq_addr_q;
  assign mreq_size     = mreq_size_q;
  assign mreq_strobe   = mreq_strobe_q;
  assign mreq_data     = mreq_data_q;
  assign iresp_addr_ok = iresp_ok_q;
  assign iresp_data_ok = iresp_ok_q;
  assign iresp_data    = iresp_data_q;
  assign dresp_addr_ok = dresp_ok_q;
  assign dresp_data_ok = dresp_ok_q;
  assign dresp_data    = dresp_data_q;

endmodule
